// File: rtl/sprite_pixel_gen.sv
// Game-object state and per-pixel colour source for the VGA display stage.
// Tracks the player, the player bullet, the enemy and the enemy bullet, and
// advances them once per frame on the falling edge of vSync. For each pixel
// strobe it registers a 3-bit colour code
// (0 bg, 1 player, 2 player bullet, 3 enemy bullet, 4 enemy).
module sprite_pixel_gen #(
   parameter int H_DISPLAY         = 640,
   parameter int V_DISPLAY         = 480,
   parameter int PLAYER_W          = 32,
   parameter int PLAYER_H          = 16,
   parameter int PLAYER_Y          = 440,
   parameter int PLAYER_SPEED      = 4,
   parameter int ENEMY_W           = 32,
   parameter int ENEMY_H           = 16,
   parameter int ENEMY_Y           = 40,
   parameter int ENEMY_SPEED       = 2,
   parameter int BULLET_W          = 4,
   parameter int BULLET_H          = 8,
   parameter int BULLET_SPEED      = 8,
   parameter int ENEMY_FIRE_PERIOD = 60
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_PixelEn,
   input  logic [9:0] i_PixelPos_X,
   input  logic [9:0] i_PixelPos_Y,
   input  logic       i_vSync,
   input  logic       i_BtnLeft,
   input  logic       i_BtnRight,
   input  logic       i_BtnFire,
   output logic [2:0] o_PixelColor,
   output logic       o_EnemyHit,
   output logic       o_PlayerHit,
   output logic [7:0] o_Score
);

   localparam int FCW = $clog2(ENEMY_FIRE_PERIOD);

   localparam logic [9:0]     PLAYER_X_RST = 10'((H_DISPLAY - PLAYER_W) / 2);
   localparam logic [9:0]     PLAYER_X_MAX = 10'(H_DISPLAY - PLAYER_W);
   localparam logic [9:0]     ENEMY_X_MAX  = 10'(H_DISPLAY - ENEMY_W);
   localparam logic [9:0]     PB_X_OFS     = 10'(PLAYER_W / 2 - BULLET_W / 2);
   localparam logic [9:0]     PB_Y_SPAWN   = 10'(PLAYER_Y - BULLET_H);
   localparam logic [9:0]     EB_X_OFS     = 10'(ENEMY_W / 2 - BULLET_W / 2);
   localparam logic [9:0]     EB_Y_SPAWN   = 10'(ENEMY_Y + ENEMY_H);
   localparam logic [FCW-1:0] FIRE_LAST    = FCW'(ENEMY_FIRE_PERIOD - 1);

   typedef enum logic {
      B_IDLE = 1'b0,
      B_FLY  = 1'b1
   } bullet_state_e;

   // Zero-extend a position so sums with box sizes cannot wrap.
   function automatic logic [10:0] ext(input logic [9:0] v);
      return {1'b0, v};
   endfunction

   // Half-open box intersection: touching edges do not count as a hit.
   function automatic logic overlap(input logic [9:0] ax, ay, input logic [10:0] aw, ah,
                                    input logic [9:0] bx, by, input logic [10:0] bw, bh);
      return (ext(ax) < ext(bx) + bw) && (ext(bx) < ext(ax) + aw) &&
             (ext(ay) < ext(by) + bh) && (ext(by) < ext(ay) + ah);
   endfunction

   // Pixel (x,y) lies in [x0,x0+w) x [y0,y0+h).
   function automatic logic covers(input logic [9:0] x, y, x0, y0, input logic [10:0] w, h);
      return (x >= x0) && (ext(x) < ext(x0) + w) && (y >= y0) && (ext(y) < ext(y0) + h);
   endfunction

   logic                vsync_q;
   logic                tick;
   logic [9:0]          player_x_q, player_x_d;
   logic [9:0]          enemy_x_q, enemy_x_d;
   logic                enemy_right_q, enemy_right_d;
   bullet_state_e       pb_state_q, pb_state_d;
   logic [9:0]          pb_x_q, pb_x_d, pb_y_q, pb_y_d;
   bullet_state_e       eb_state_q, eb_state_d;
   logic [9:0]          eb_x_q, eb_x_d, eb_y_q, eb_y_d;
   logic [FCW-1:0]      fire_cnt_q, fire_cnt_d;
   logic [7:0]          score_q, score_d;
   logic                enemy_hit_q, enemy_hit_d;
   logic                player_hit_q, player_hit_d;
   logic [2:0]          pix_q, colour_code;

   // One-clock frame tick on the falling edge of vSync.
   assign tick = vsync_q & ~i_vSync;

   // Per-frame update of all objects; collision checks read pre-tick positions.
   always_comb begin
      // NOTE: every next-state value is defaulted to its current value first, so
      // branches that leave a signal untouched cannot infer a latch.
      player_x_d    = player_x_q;
      enemy_x_d     = enemy_x_q;
      enemy_right_d = enemy_right_q;
      pb_state_d    = pb_state_q;
      pb_x_d        = pb_x_q;
      pb_y_d        = pb_y_q;
      eb_state_d    = eb_state_q;
      eb_x_d        = eb_x_q;
      eb_y_d        = eb_y_q;
      fire_cnt_d    = fire_cnt_q;
      score_d       = score_q;
      enemy_hit_d   = 1'b0;
      player_hit_d  = 1'b0;

      if (tick) begin
         // Player: exactly one direction button moves it, clamped to the screen.
         if (i_BtnLeft && !i_BtnRight) begin
            if (player_x_q < 10'(PLAYER_SPEED)) player_x_d = '0;
            else                                player_x_d = player_x_q - 10'(PLAYER_SPEED);
         end else if (i_BtnRight && !i_BtnLeft) begin
            if (ext(player_x_q) + 11'(PLAYER_SPEED) > ext(PLAYER_X_MAX)) player_x_d = PLAYER_X_MAX;
            else                                                        player_x_d = player_x_q + 10'(PLAYER_SPEED);
         end

         // Enemy: patrols, clamping and reversing when it reaches either edge.
         if (enemy_right_q) begin
            if (ext(enemy_x_q) + 11'(ENEMY_SPEED) >= ext(ENEMY_X_MAX)) begin
               enemy_x_d     = ENEMY_X_MAX;
               enemy_right_d = 1'b0;
            end else begin
               enemy_x_d = enemy_x_q + 10'(ENEMY_SPEED);
            end
         end else begin
            if (enemy_x_q <= 10'(ENEMY_SPEED)) begin
               enemy_x_d     = '0;
               enemy_right_d = 1'b1;
            end else begin
               enemy_x_d = enemy_x_q - 10'(ENEMY_SPEED);
            end
         end

         // Player bullet: launch from the player's centre; a bullet retiring this
         // tick cannot be relaunched until the next tick.
         if (pb_state_q == B_IDLE) begin
            if (i_BtnFire) begin
               pb_state_d = B_FLY;
               pb_x_d     = player_x_q + PB_X_OFS;
               pb_y_d     = PB_Y_SPAWN;
            end
         end else if (overlap(pb_x_q, pb_y_q, 11'(BULLET_W), 11'(BULLET_H),
                              enemy_x_q, 10'(ENEMY_Y), 11'(ENEMY_W), 11'(ENEMY_H))) begin
            pb_state_d  = B_IDLE;
            enemy_hit_d = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
         end else if (pb_y_q < 10'(BULLET_SPEED)) begin
            pb_state_d = B_IDLE;
         end else begin
            pb_y_d = pb_y_q - 10'(BULLET_SPEED);
         end

         // Enemy bullet: the shot counter parks at its last value while a shot
         // is in flight, so the next shot follows on the first idle tick.
         if (eb_state_q == B_IDLE) begin
            if (fire_cnt_q == FIRE_LAST) begin
               fire_cnt_d = '0;
               eb_state_d = B_FLY;
               eb_x_d     = enemy_x_q + EB_X_OFS;
               eb_y_d     = EB_Y_SPAWN;
            end else begin
               fire_cnt_d = fire_cnt_q + FCW'(1);
            end
         end else begin
            if (fire_cnt_q != FIRE_LAST) fire_cnt_d = fire_cnt_q + FCW'(1);
            if (overlap(eb_x_q, eb_y_q, 11'(BULLET_W), 11'(BULLET_H),
                        player_x_q, 10'(PLAYER_Y), 11'(PLAYER_W), 11'(PLAYER_H))) begin
               eb_state_d   = B_IDLE;
               player_hit_d = 1'b1;
            end else if (ext(eb_y_q) + 11'(BULLET_H) + 11'(BULLET_SPEED) > 11'(V_DISPLAY)) begin
               eb_state_d = B_IDLE;
            end else begin
               eb_y_d = eb_y_q + 10'(BULLET_SPEED);
            end
         end
      end
   end

   // Colour of the addressed pixel: bullets in flight first, then player, then enemy.
   always_comb begin
      colour_code = 3'd0;
      if (i_PixelPos_X < 10'(H_DISPLAY) && i_PixelPos_Y < 10'(V_DISPLAY)) begin
         if (pb_state_q == B_FLY &&
             covers(i_PixelPos_X, i_PixelPos_Y, pb_x_q, pb_y_q, 11'(BULLET_W), 11'(BULLET_H)))
            colour_code = 3'd2;
         else if (eb_state_q == B_FLY &&
                  covers(i_PixelPos_X, i_PixelPos_Y, eb_x_q, eb_y_q, 11'(BULLET_W), 11'(BULLET_H)))
            colour_code = 3'd3;
         else if (covers(i_PixelPos_X, i_PixelPos_Y, player_x_q, 10'(PLAYER_Y),
                         11'(PLAYER_W), 11'(PLAYER_H)))
            colour_code = 3'd1;
         else if (covers(i_PixelPos_X, i_PixelPos_Y, enemy_x_q, 10'(ENEMY_Y),
                         11'(ENEMY_W), 11'(ENEMY_H)))
            colour_code = 3'd4;
      end
   end

   // State registers; reset is asynchronous and takes effect mid-frame.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         vsync_q       <= 1'b1;
         player_x_q    <= PLAYER_X_RST;
         enemy_x_q     <= '0;
         enemy_right_q <= 1'b1;
         pb_state_q    <= B_IDLE;
         pb_x_q        <= '0;
         pb_y_q        <= '0;
         eb_state_q    <= B_IDLE;
         eb_x_q        <= '0;
         eb_y_q        <= '0;
         fire_cnt_q    <= '0;
         score_q       <= '0;
         enemy_hit_q   <= 1'b0;
         player_hit_q  <= 1'b0;
         pix_q         <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         vsync_q       <= i_vSync;
         player_x_q    <= player_x_d;
         enemy_x_q     <= enemy_x_d;
         enemy_right_q <= enemy_right_d;
         pb_state_q    <= pb_state_d;
         pb_x_q        <= pb_x_d;
         pb_y_q        <= pb_y_d;
         eb_state_q    <= eb_state_d;
         eb_x_q        <= eb_x_d;
         eb_y_q        <= eb_y_d;
         fire_cnt_q    <= fire_cnt_d;
         score_q       <= score_d;
         enemy_hit_q   <= enemy_hit_d;
         player_hit_q  <= player_hit_d;
         if (i_PixelEn) pix_q <= colour_code;
      end
   end

   assign o_PixelColor = pix_q;
   assign o_EnemyHit   = enemy_hit_q;
   assign o_PlayerHit  = player_hit_q;
   assign o_Score      = score_q;

endmodule
